// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter.
// Two requester channels plus one response channel.
interface adder_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic       req0_mode;
   logic       req1_valid;
   logic       req1_ready;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic       req1_mode;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_sum;
   logic       rsp_carry;
   logic       rsp_overflow;

   modport master (
      output req0_valid, req0_a, req0_b, req0_mode,
      output req1_valid, req1_a, req1_b, req1_mode,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_mode,
      input  req1_valid, req1_a, req1_b, req1_mode,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
   );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 8-bit adder/subtractor.
// One operation in flight: IDLE -> EXEC -> RESP.
module adder (
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic       mode,
   output logic [7:0] final_sum,
   output logic       final_carry_out,
   output logic       overflow
);
   logic [7:0] b_eff;
   logic [8:0] full;

   assign b_eff           = data1 ^ {8{mode}};
   assign full            = {1'b0, data0} + {1'b0, b_eff} + {8'd0, mode};
   assign final_sum       = full[7:0];
   assign final_carry_out = full[8];
   assign overflow        = (data0[7] == b_eff[7]) & (full[7] != data0[7]);
endmodule

module adder_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic              clk,
   input logic              reset,
   adder_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic       mode_q, mode_d;
   logic       id_q, id_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [7:0] rsp_sum_q, rsp_sum_d;
   logic       rsp_carry_q, rsp_carry_d;
   logic       rsp_ovf_q, rsp_ovf_d;

   logic       gnt0, gnt1;
   logic       is_idle;
   logic       acc0, acc1;
   logic [7:0] sum_w;
   logic       carry_w, ovf_w;

   // Pointer only matters on a tie; a lone requester always wins.
   assign gnt1    = bus.req1_valid &
                    (~bus.req0_valid | (ptr_q & ~FIXED_PRIO));
   assign gnt0    = bus.req0_valid & ~gnt1;
   assign is_idle = (state_q == IDLE) & ~reset;

   assign bus.req0_ready = is_idle & gnt0;
   assign bus.req1_ready = is_idle & gnt1;
   assign acc0           = bus.req0_valid & bus.req0_ready;
   assign acc1           = bus.req1_valid & bus.req1_ready;

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_sum      = rsp_sum_q;
   assign bus.rsp_carry    = rsp_carry_q;
   assign bus.rsp_overflow = rsp_ovf_q;

   adder u_adder (
      .data0           (a_q),
      .data1           (b_q),
      .mode            (mode_q),
      .final_sum       (sum_w),
      .final_carry_out (carry_w),
      .overflow        (ovf_w)
   );

   // Next-state: latch on accept, compute in EXEC, hold until taken.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      mode_d      = mode_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_carry_d = rsp_carry_q;
      rsp_ovf_d   = rsp_ovf_q;
      unique case (state_q)
         IDLE: begin
            if (acc0) begin
               a_d     = bus.req0_a;
               b_d     = bus.req0_b;
               mode_d  = bus.req0_mode;
               id_d    = 1'b0;
               ptr_d   = 1'b1;
               state_d = EXEC;
            end else if (acc1) begin
               a_d     = bus.req1_a;
               b_d     = bus.req1_b;
               mode_d  = bus.req1_mode;
               id_d    = 1'b1;
               ptr_d   = 1'b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_sum_d   = sum_w;
            rsp_carry_d = carry_w;
            rsp_ovf_d   = ovf_w;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         mode_q      <= 1'b0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_sum_q   <= 8'd0;
         rsp_carry_q <= 1'b0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mode_q      <= mode_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed + scoreboard bench for adder_arbiter.
// Instance dut0 is round-robin, dut1 is fixed priority.
module tb_adder_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   adder_arbiter_if ifc ();
   adder_arbiter_if ifc1 ();

   adder_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
      .clk   (clk),
      .reset (rst),
      .bus   (ifc.slave)
   );

   adder_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
      .clk   (clk),
      .reset (rst),
      .bus   (ifc1.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, carry, sum} from integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic m);
      int ua, ub, sa, sb, r, u;
      logic ovf, cy;
      logic [7:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = a[7] ? ua - 256 : ua;
      sb = b[7] ? ub - 256 : ub;
      r  = m ? sa - sb : sa + sb;
      u  = m ? ua - ub : ua + ub;
      ovf = (r > 127) || (r < -128);
      cy  = m ? (ua >= ub) : (u > 255);
      s   = u[7:0];
      return {ovf, cy, s};
   endfunction

   // One directed operation on dut0, starting in IDLE at posedge+1.
   task automatic op0(input string tag, input logic id,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic m);
      logic [9:0] e;
      e = model(a, b, m);
      ifc.rsp_ready = 1'b1;
      if (id) begin
         ifc.req1_valid = 1'b1;
         ifc.req1_a = a; ifc.req1_b = b; ifc.req1_mode = m;
      end else begin
         ifc.req0_valid = 1'b1;
         ifc.req0_a = a; ifc.req0_b = b; ifc.req0_mode = m;
      end
      #1;
      chk({tag, "_rdy"},
          id ? ifc.req1_ready : ifc.req0_ready, 1);
      @(posedge clk); #1;
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b0;
      chk({tag, "_exec_v"}, ifc.rsp_valid, 0);
      @(posedge clk); #1;
      chk({tag, "_rsp"},
          {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_overflow,
           ifc.rsp_carry, ifc.rsp_sum},
          {1'b1, id, e});
      @(posedge clk); #1;
      chk({tag, "_drop"}, ifc.rsp_valid, 0);
   endtask

   logic [10:0] sbq[$];
   logic [10:0] ex;
   logic        g0[4];
   logic        g1[4];
   int          n0, n1, nacc;
   logic [3:0]  rr_exp;

   task automatic scoreboard_step();
      chk("excl_ready", ifc.req0_ready & ifc.req1_ready, 0);
      if (ifc.req0_valid && ifc.req0_ready) begin
         sbq.push_back({1'b0, model(ifc.req0_a, ifc.req0_b,
                                    ifc.req0_mode)});
         nacc++;
      end
      if (ifc.req1_valid && ifc.req1_ready) begin
         sbq.push_back({1'b1, model(ifc.req1_a, ifc.req1_b,
                                    ifc.req1_mode)});
         nacc++;
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
         chk("rsp_expected", sbq.size() > 0, 1);
         if (sbq.size() > 0) begin
            ex = sbq.pop_front();
            chk("rand_rsp",
                {ifc.rsp_id, ifc.rsp_overflow,
                 ifc.rsp_carry, ifc.rsp_sum}, ex);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
      ifc.req0_a = 8'h12; ifc.req0_b = 8'h34; ifc.req0_mode = 1'b0;
      ifc.req1_a = 8'h56; ifc.req1_b = 8'h78; ifc.req1_mode = 1'b1;
      ifc.rsp_ready = 1'b1;
      ifc1.req0_valid = 1'b0; ifc1.req1_valid = 1'b0;
      ifc1.req0_a = 8'h00; ifc1.req0_b = 8'h00; ifc1.req0_mode = 1'b0;
      ifc1.req1_a = 8'h00; ifc1.req1_b = 8'h00; ifc1.req1_mode = 1'b0;
      ifc1.rsp_ready = 1'b1;

      // Reset state, readys held low even with both valid.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_sum,
                      ifc.rsp_carry, ifc.rsp_overflow}, 0);
      chk("rst_rdy", {ifc.req0_ready, ifc.req1_ready}, 0);
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Arithmetic directed vectors.
      op0("add7f01", 1'b0, 8'h7F, 8'h01, 1'b0);
      chk("add7f01_val", {ifc.rsp_sum, ifc.rsp_carry,
                          ifc.rsp_overflow}, {8'h80, 1'b0, 1'b1});
      op0("sub0001", 1'b1, 8'h00, 8'h01, 1'b1);
      chk("sub0001_val", {ifc.rsp_sum, ifc.rsp_carry,
                          ifc.rsp_overflow}, {8'hFF, 1'b0, 1'b0});
      op0("addff01", 1'b1, 8'hFF, 8'h01, 1'b0);
      chk("addff01_val", {ifc.rsp_sum, ifc.rsp_carry,
                          ifc.rsp_overflow}, {8'h00, 1'b1, 1'b0});
      op0("sub8001", 1'b0, 8'h80, 8'h01, 1'b1);
      op0("sub0505", 1'b1, 8'h05, 8'h05, 1'b1);

      // Grant order with both valid from reset.
      rst = 1'b1;
      ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
      ifc1.req0_valid = 1'b1; ifc1.req1_valid = 1'b1;
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
         if (n0 < 4 && ifc.req0_ready) begin
            g0[n0] = 1'b0; n0++;
         end else if (n0 < 4 && ifc.req1_ready) begin
            g0[n0] = 1'b1; n0++;
         end
         if (n1 < 4 && ifc1.req0_ready) begin
            g1[n1] = 1'b0; n1++;
         end else if (n1 < 4 && ifc1.req1_ready) begin
            g1[n1] = 1'b1; n1++;
         end
         @(posedge clk); #1;
      end
      chk("rr_count", n0, 4);
      chk("fp_count", n1, 4);
      rr_exp = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), g0[i], rr_exp[i]);
         chk($sformatf("fp_grant%0d", i), g1[i], 1'b0);
      end
      ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
      ifc1.req0_valid = 1'b0; ifc1.req1_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Backpressure hold; requester inputs change meanwhile.
      ifc.req0_valid = 1'b1;
      ifc.req0_a = 8'h10; ifc.req0_b = 8'h20; ifc.req0_mode = 1'b0;
      ifc.rsp_ready = 1'b0;
      #1;
      chk("bp_rdy0", ifc.req0_ready, 1);
      @(posedge clk); #1;
      ifc.req0_a = 8'hAA; ifc.req0_b = 8'h55; ifc.req0_mode = 1'b1;
      ifc.req1_valid = 1'b1;
      ifc.req1_a = 8'h05; ifc.req1_b = 8'h07; ifc.req1_mode = 1'b1;
      #1;
      chk("bp_exec_v", ifc.rsp_valid, 0);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_hold%0d", k),
             {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_sum, ifc.rsp_carry,
              ifc.rsp_overflow, ifc.req0_ready, ifc.req1_ready},
             {1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
         @(posedge clk); #1;
      end
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_v", ifc.rsp_valid, 0);
      chk("bp_next_rdy", {ifc.req0_ready, ifc.req1_ready}, 2'b01);
      @(posedge clk); #1;
      ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
      chk("bp_next_exec", ifc.rsp_valid, 0);
      @(posedge clk); #1;
      chk("bp_next_rsp",
          {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_sum,
           ifc.rsp_carry, ifc.rsp_overflow},
          {1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
      @(posedge clk); #1;

      // Reset in the middle of EXEC.
      ifc.req0_valid = 1'b1;
      ifc.req0_a = 8'h01; ifc.req0_b = 8'h01; ifc.req0_mode = 1'b0;
      #1;
      chk("mr_rdy0", ifc.req0_ready, 1);
      @(posedge clk); #1;
      ifc.req0_a = 8'h40; ifc.req0_b = 8'h40;
      ifc.req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("mr_rst", {ifc.rsp_valid, ifc.req0_ready, ifc.req1_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mr_first_grant", {ifc.req0_ready, ifc.req1_ready}, 2'b10);
      @(posedge clk); #1;
      ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
      chk("mr_no_stale", ifc.rsp_valid, 0);
      @(posedge clk); #1;
      chk("mr_rsp",
          {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_sum,
           ifc.rsp_carry, ifc.rsp_overflow},
          {1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
      @(posedge clk); #1;

      // Random traffic against the scoreboard.
      nacc = 0;
      for (int c = 0; c < 400; c++) begin
         ifc.req0_valid = ($urandom_range(0, 3) != 0);
         ifc.req0_a     = 8'($urandom_range(0, 255));
         ifc.req0_b     = 8'($urandom_range(0, 255));
         ifc.req0_mode  = 1'($urandom_range(0, 1));
         ifc.req1_valid = ($urandom_range(0, 3) != 0);
         ifc.req1_a     = 8'($urandom_range(0, 255));
         ifc.req1_b     = 8'($urandom_range(0, 255));
         ifc.req1_mode  = 1'($urandom_range(0, 1));
         ifc.rsp_ready  = 1'($urandom_range(0, 1));
         #1;
         scoreboard_step();
         @(posedge clk); #1;
      end
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b0;
      ifc.rsp_ready  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         scoreboard_step();
         @(posedge clk); #1;
      end
      chk("rand_q_empty", sbq.size(), 0);
      chk("rand_enough", nacc >= 30, 1);
      chk("rand_end_v", ifc.rsp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
